// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Operand pattern of the one quotient that cannot be represented: MIN / -1.
    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_OVF_DIVISOR  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Start/done handshake and operand/result bundle for the divider.
interface divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, div_zero, overflow, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, div_zero, overflow, busy, done
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift in the next dividend bit, trial-subtract, keep or restore.
    // The partial remainder is always below the divisor, so the shifted
    // value is below 2*divisor and the WIDTH+1-bit difference cannot wrap.
    always_comb begin
        shifted = {rem_in, shift_in};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed divider: C semantics (truncate toward zero, remainder
// follows the dividend), fixed latency, div-by-zero and overflow flags.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    divider_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;        // partial remainder magnitude
    logic [WIDTH-1:0] quo_reg;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_reg;        // divisor magnitude
    logic [WIDTH-1:0] dividend_reg;   // original dividend, returned on divide-by-zero
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             dz_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_zero_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_reg),
        .shift_in (quo_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .rem_out  (step_rem),
        .q_bit    (step_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state: start only honoured in IDLE, WIDTH steps in RUN, one FIX cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (count_reg == CW'(WIDTH-1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture (magnitudes via WIDTH+1-bit negate so MIN is exact) and iteration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        quo_reg      <= bus.dividend[WIDTH-1]
                                        ? WIDTH'(-{bus.dividend[WIDTH-1], bus.dividend})
                                        : bus.dividend;
                        dvs_reg      <= bus.divisor[WIDTH-1]
                                        ? WIDTH'(-{bus.divisor[WIDTH-1], bus.divisor})
                                        : bus.divisor;
                        dividend_reg <= bus.dividend;
                        neg_q_reg    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r_reg    <= bus.dividend[WIDTH-1];
                        dz_reg       <= (bus.divisor == '0);
                        ovf_reg      <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                        rem_reg      <= '0;
                        count_reg    <= '0;
                    end
                end
                RUN: begin
                    rem_reg   <= step_rem;
                    quo_reg   <= {quo_reg[WIDTH-2:0], step_bit};
                    count_reg <= count_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: loaded only in FIX, otherwise hold the last result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (state_reg == FIX) begin
            if (dz_reg) begin
                quotient_reg  <= '1;
                remainder_reg <= dividend_reg;
                div_zero_reg  <= 1'b1;
                overflow_reg  <= 1'b0;
            end else begin
                // MIN / -1 yields magnitude 2^(WIDTH-1) with positive sign,
                // which wraps naturally to MIN.
                quotient_reg  <= neg_q_reg ? -quo_reg : quo_reg;
                remainder_reg <= neg_r_reg ? -rem_reg : rem_reg;
                div_zero_reg  <= 1'b0;
                overflow_reg  <= ovf_reg;
            end
        end
    end

    // Status: busy tracks the non-IDLE states, done pulses on the FIX exit edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= (state_reg == FIX);
        end
    end

    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the signed divider: C-semantics results, flags,
// fixed latency, busy/done behaviour, ignored start, chained start, reset abort.
module tb_divider;
    import div_pkg::*;

    localparam int W = DIV_WIDTH_DEFAULT;
    localparam logic [W-1:0] MIN = DIV_OVF_DIVIDEND;
    localparam logic [W-1:0] MAX = 32'h7FFF_FFFF;

    logic clk;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   dones;

    divider_if #(.WIDTH(W)) bus ();

    divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; caller is positioned just after a rising edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done, then check latency, results and flags.
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic dz, input logic ov);
        int   lat = 0;
        logic got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            got = bus.done;
        end
        $display("%s: done after %0d cycles q=%h r=%h dz=%b ov=%b",
                 tag, lat, bus.quotient, bus.remainder, bus.div_zero, bus.overflow);
        chk({tag, "/latency"}, W'(lat), W'(exp_lat));
        chk({tag, "/quotient"}, bus.quotient, q);
        chk({tag, "/remainder"}, bus.remainder, r);
        chk({tag, "/div_zero"}, W'(bus.div_zero), W'(dz));
        chk({tag, "/overflow"}, W'(bus.overflow), W'(ov));
        chk({tag, "/busy_at_done"}, W'(bus.busy), '0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dz, input logic ov);
        start_op(a, b);
        chk({tag, "/busy"}, W'(bus.busy), W'(1));
        wait_done(tag, 33, q, r, dz, ov);
        @(posedge clk);
        #1;
        chk({tag, "/done_one_cycle"}, W'(bus.done), '0);
        chk({tag, "/result_held"}, bus.quotient, q);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/quotient", bus.quotient, '0);
        chk("rst/remainder", bus.remainder, '0);
        chk("rst/div_zero", W'(bus.div_zero), '0);
        chk("rst/overflow", W'(bus.overflow), '0);
        chk("rst/busy", W'(bus.busy), '0);
        chk("rst/done", W'(bus.done), '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Sign combinations, zero divisor, overflow and MIN/MAX corners.
        run("p100_p7",  32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0);
        run("n100_p7",  -32'sd100,    32'd7,        -32'sd14,     -32'sd2,      1'b0, 1'b0);
        run("p100_n7",  32'd100,      -32'sd7,      -32'sd14,     32'd2,        1'b0, 1'b0);
        run("n100_n7",  -32'sd100,    -32'sd7,      32'd14,       -32'sd2,      1'b0, 1'b0);
        run("p1234_0",  32'd1234,     32'd0,        32'hFFFF_FFFF, 32'd1234,    1'b1, 1'b0);
        run("n5_0",     -32'sd5,      32'd0,        32'hFFFF_FFFF, -32'sd5,     1'b1, 1'b0);
        run("min_n1",   MIN,          32'hFFFF_FFFF, MIN,         32'd0,        1'b0, 1'b1);
        run("min_p1",   MIN,          32'd1,        MIN,          32'd0,        1'b0, 1'b0);
        run("min_min",  MIN,          MIN,          32'd1,        32'd0,        1'b0, 1'b0);
        run("max_min",  MAX,          MIN,          32'd0,        MAX,          1'b0, 1'b0);
        run("min_max",  MIN,          MAX,          -32'sd1,      -32'sd1,      1'b0, 1'b0);
        run("max_n1",   MAX,          -32'sd1,      32'h8000_0001, 32'd0,       1'b0, 1'b0);
        run("p7_p100",  32'd7,        32'd100,      32'd0,        32'd7,        1'b0, 1'b0);
        run("n7_p2",    -32'sd7,      32'd2,        -32'sd3,      -32'sd1,      1'b0, 1'b0);

        // start during an operation is ignored: first result, original timing.
        start_op(32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start_op(32'd50, 32'd5);
        wait_done("busy_start", 28, 32'd14, 32'd2, 1'b0, 1'b0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("busy_start/no_second_done", W'(dones), '0);
        chk("busy_start/result_kept", bus.quotient, 32'd14);

        // start coincident with done is accepted; old result not cleared by start.
        start_op(32'd1000, 32'd10);
        wait_done("chain1", 33, 32'd100, 32'd0, 1'b0, 1'b0);
        start_op(-32'sd100, -32'sd7);
        chk("chain2/busy", W'(bus.busy), W'(1));
        chk("chain2/old_result_held", bus.quotient, 32'd100);
        wait_done("chain2", 33, 32'd14, -32'sd2, 1'b0, 1'b0);

        // Reset mid-operation aborts immediately with no done.
        start_op(32'd1234, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("abort/quotient", bus.quotient, '0);
        chk("abort/remainder", bus.remainder, '0);
        chk("abort/busy", W'(bus.busy), '0);
        chk("abort/done", W'(bus.done), '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        $display("abort: %0d done pulses after reset", dones);
        chk("abort/no_done", W'(dones), '0);
        chk("abort/quotient_after", bus.quotient, '0);

        run("post_reset", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
